// File: rtl/memory_access_stage.sv
// M stage of the pipeline: issues one data-memory access per memory op, stalls upstream until it completes,
// and registers the MEM/WB results. Optional request timeout is enabled with `define MEM_TIMEOUT_EN.
module memory_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        luiM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RDM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ExtImmM,
  input  logic [31:0] PCPlus4M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [4:0]  RDW,
  output logic [31:0] ResultW,
  output logic        mem_err,
  output logic        dbg_state
);

  // Handshake: mem_req holds for the whole REQ state with address/data taken straight from the
  // (stalled, therefore stable) M inputs; the access completes on any REQ cycle where mem_ready=1.
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        mem_op, is_load, stall, expire;
  logic [31:0] alu_path;

  assign mem_op    = MemWriteM | (ResultSrcM == 2'b01);
  assign is_load   = (ResultSrcM == 2'b01) & ~MemWriteM;
  assign mem_addr  = ALUResultM;
  assign mem_wdata = WriteDataM;
  assign dbg_state = (state == REQ);
  // Gating with rst_n keeps the stall from lingering while reset is held over a memory op.
  assign StallM    = stall & rst_n;

  always_comb begin
    if (luiM)                     alu_path = ExtImmM;
    else if (ResultSrcM == 2'b10) alu_path = PCPlus4M;
    else                          alu_path = ALUResultM;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] tmo_cnt;

  // A completing mem_ready in the expiry cycle takes priority over the timeout.
  assign expire = (state == REQ) && !mem_ready && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == REQ) tmo_cnt <= '0;
      else if (state == REQ && !mem_ready)   tmo_cnt <= tmo_cnt + CW'(1);
      if (expire) mem_err <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYCLES;
  assign expire     = 1'b0;
  assign mem_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        mem_we  = MemWriteM;
        if (mem_ready || expire) state_nxt = IDLE;
        else                     stall     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteW <= 1'b0;
      RDW       <= '0;
      ResultW   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!mem_op) begin
            RegWriteW <= RegWriteM;
            RDW       <= RDM;
            ResultW   <= alu_path;
          end else begin
            RegWriteW <= 1'b0;
          end
        end
        REQ: begin
          if (mem_ready) begin
            RegWriteW <= RegWriteM;
            RDW       <= RDM;
            ResultW   <= is_load ? mem_rdata : ALUResultM;
          end else begin
            RegWriteW <= 1'b0;
          end
        end
        default: RegWriteW <= 1'b0;
      endcase
    end
  end

endmodule
